// File: rtl/ctrl_ramdrv_ringbuf_mc.sv
// Multi-channel ring-buffer address driver: per-channel segment registers, push
// address generation and a newest-to-oldest read scan with ready/valid handshake.
module ctrl_ramdrv_ringbuf_mc #(
    parameter int ADDR_WIDTH = 12,
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_WIDTH-1:0]   cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_lo,
    input  logic [ADDR_WIDTH-1:0] cfg_hi,
    input  logic                  wr_req,
    input  logic [CH_WIDTH-1:0]   wr_ch,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  rd_start,
    input  logic [CH_WIDTH-1:0]   rd_ch,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  err
);

    localparam int CH_SLOTS = 1 << CH_WIDTH;
    localparam logic [CH_WIDTH:0] CH_LIMIT = CH_NUM[CH_WIDTH:0];

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

    function automatic logic [ADDR_WIDTH-1:0] step_up(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] lo,
                                                      input logic [ADDR_WIDTH-1:0] hi);
        return (a == hi) ? lo : a + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_down(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [ADDR_WIDTH-1:0] lo,
                                                        input logic [ADDR_WIDTH-1:0] hi);
        return (a == lo) ? hi : a - ADDR_WIDTH'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] lo_q   [CH_SLOTS];
    logic [ADDR_WIDTH-1:0] hi_q   [CH_SLOTS];
    logic [ADDR_WIDTH-1:0] head_q [CH_SLOTS];
    logic [ADDR_WIDTH-1:0] lo_d   [CH_SLOTS];
    logic [ADDR_WIDTH-1:0] hi_d   [CH_SLOTS];
    logic [ADDR_WIDTH-1:0] head_d [CH_SLOTS];

    state_t                state_q, state_d;
    logic [CH_WIDTH-1:0]   scan_ch_q, scan_ch_d;
    logic [ADDR_WIDTH-1:0] scan_lo_q, scan_lo_d, scan_hi_q, scan_hi_d, scan_tail_q, scan_tail_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                  wr_valid_q, wr_valid_d, err_q, err_d;

    logic                  start_ok_s, cfg_ok_s, push_ok_s, lock_valid_s;
    logic [CH_WIDTH-1:0]   lock_ch_s;
    logic [ADDR_WIDTH-1:0] new_head_s, start_tail_s, down_s;

    // Next-state logic: command acceptance, segment registers and the scan FSM.
    always_comb begin
        lo_d        = lo_q;
        hi_d        = hi_q;
        head_d      = head_q;
        state_d     = state_q;
        scan_ch_d   = scan_ch_q;
        scan_lo_d   = scan_lo_q;
        scan_hi_d   = scan_hi_q;
        scan_tail_d = scan_tail_q;
        rd_addr_d   = rd_addr_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_addr_d   = wr_addr_q;

        start_ok_s   = rd_start && (state_q == ST_IDLE) && ({1'b0, rd_ch} < CH_LIMIT);
        // A channel whose scan starts this cycle is already locked, so the snapshot stays coherent.
        lock_valid_s = (state_q == ST_SCAN) || start_ok_s;
        lock_ch_s    = (state_q == ST_SCAN) ? scan_ch_q : rd_ch;
        cfg_ok_s     = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT) && (cfg_lo <= cfg_hi) &&
                       !(lock_valid_s && (cfg_ch == lock_ch_s));
        push_ok_s    = wr_req && ({1'b0, wr_ch} < CH_LIMIT) &&
                       !(lock_valid_s && (wr_ch == lock_ch_s)) &&
                       !(cfg_we && (cfg_ch == wr_ch));
        err_d        = (cfg_we && !cfg_ok_s) || (wr_req && !push_ok_s) || (rd_start && !start_ok_s);

        new_head_s   = step_up(head_q[wr_ch], lo_q[wr_ch], hi_q[wr_ch]);
        start_tail_s = step_up(head_q[rd_ch], lo_q[rd_ch], hi_q[rd_ch]);
        down_s       = step_down(rd_addr_q, scan_lo_q, scan_hi_q);

        if (cfg_ok_s) begin
            lo_d[cfg_ch]   = cfg_lo;
            hi_d[cfg_ch]   = cfg_hi;
            head_d[cfg_ch] = cfg_lo;
        end else begin
            lo_d = lo_q;
        end

        wr_valid_d = push_ok_s;
        if (push_ok_s) begin
            head_d[wr_ch] = new_head_s;
            wr_addr_d     = new_head_s;
        end else begin
            wr_addr_d = wr_addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d     = ST_SCAN;
                    scan_ch_d   = rd_ch;
                    scan_lo_d   = lo_q[rd_ch];
                    scan_hi_d   = hi_q[rd_ch];
                    scan_tail_d = start_tail_s;
                    rd_addr_d   = head_q[rd_ch];
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (head_q[rd_ch] == start_tail_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_valid_q && rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = ST_IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        rd_addr_d = down_s;
                        rd_last_d = (down_s == scan_tail_q);
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_SLOTS; i++) begin
                lo_q[i]   <= '0;
                hi_q[i]   <= '0;
                head_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            scan_ch_q   <= '0;
            scan_lo_q   <= '0;
            scan_hi_q   <= '0;
            scan_tail_q <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            head_q      <= head_d;
            state_q     <= state_d;
            scan_ch_q   <= scan_ch_d;
            scan_lo_q   <= scan_lo_d;
            scan_hi_q   <= scan_hi_d;
            scan_tail_q <= scan_tail_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            wr_addr_q   <= wr_addr_d;
            wr_valid_q  <= wr_valid_d;
            err_q       <= err_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_addr  = rd_addr_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state_q == ST_SCAN);
    assign err      = err_q;

endmodule

// File: tb/tb_ctrl_ramdrv_ringbuf_mc.sv
// Bench for ctrl_ramdrv_ringbuf_mc: directed vector table with hand-derived
// expectations, then random traffic against a list-based reference model.
module tb_ctrl_ramdrv_ringbuf_mc;

    localparam int AW  = 12;
    localparam int CHN = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [AW-1:0] cfg_lo = '0, cfg_hi = '0;
    logic          wr_req = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic          rd_start = 1'b0;
    logic [CW-1:0] rd_ch = '0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_last, busy, err;

    always #5 clk = ~clk;

    ctrl_ramdrv_ringbuf_mc #(.ADDR_WIDTH(AW), .CH_NUM(CHN), .CH_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .wr_req(wr_req), .wr_ch(wr_ch), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .rd_start(rd_start), .rd_ch(rd_ch), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_last(rd_last),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is the explicit list of addresses newest to oldest.
    int m_lo[CHN], m_hi[CHN], m_head[CHN];
    bit m_busy;
    int m_sch, m_idx;
    int m_list[$];
    int e_wv, e_wa, e_rv, e_ra, e_rl, e_err;

    task automatic model_reset();
        for (int c = 0; c < CHN; c++) begin
            m_lo[c] = 0; m_hi[c] = 0; m_head[c] = 0;
        end
        m_busy = 0; m_sch = 0; m_idx = 0; m_list.delete();
        e_wv = 0; e_wa = 0; e_rv = 0; e_ra = 0; e_rl = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit start_ok, lk, cfg_ok, push_ok;
        int lkch, n, c_lo, c_hi;
        if (rst) begin
            model_reset();
            return;
        end
        c_lo     = int'(cfg_lo);
        c_hi     = int'(cfg_hi);
        start_ok = rd_start && !m_busy && (int'(rd_ch) < CHN);
        lk       = m_busy || start_ok;
        lkch     = m_busy ? m_sch : int'(rd_ch);
        cfg_ok   = cfg_we && (int'(cfg_ch) < CHN) && (c_lo <= c_hi) && !(lk && int'(cfg_ch) == lkch);
        push_ok  = wr_req && (int'(wr_ch) < CHN) && !(lk && int'(wr_ch) == lkch) &&
                   !(cfg_we && cfg_ch == wr_ch);
        e_err    = (cfg_we && !cfg_ok) || (wr_req && !push_ok) || (rd_start && !start_ok);
        if (m_busy) begin
            if (e_rv == 1 && rd_ready) begin
                m_idx++;
                if (m_idx == m_list.size()) begin
                    m_busy = 0; e_rv = 0; e_rl = 0;
                end else begin
                    e_ra = m_list[m_idx];
                    e_rl = (m_idx == m_list.size() - 1);
                end
            end
        end else if (start_ok) begin
            n = m_hi[rd_ch] - m_lo[rd_ch] + 1;
            m_list.delete();
            for (int k = 0; k < n; k++)
                m_list.push_back(m_lo[rd_ch] + ((m_head[rd_ch] - m_lo[rd_ch]) - k + n) % n);
            m_idx = 0; m_busy = 1; m_sch = int'(rd_ch);
            e_rv = 1; e_ra = m_list[0]; e_rl = (n == 1);
        end
        e_wv = push_ok;
        if (push_ok) begin
            m_head[wr_ch] = (m_head[wr_ch] == m_hi[wr_ch]) ? m_lo[wr_ch] : m_head[wr_ch] + 1;
            e_wa = m_head[wr_ch];
        end
        if (cfg_ok) begin
            m_lo[cfg_ch] = c_lo; m_hi[cfg_ch] = c_hi; m_head[cfg_ch] = c_lo;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_wr_valid", 32'(wr_valid), 32'(e_wv));
        chk("model_wr_addr",  32'(wr_addr),  32'(e_wa));
        chk("model_rd_valid", 32'(rd_valid), 32'(e_rv));
        chk("model_rd_addr",  32'(rd_addr),  32'(e_ra));
        chk("model_rd_last",  32'(rd_last),  32'(e_rl));
        chk("model_busy",     32'(busy),     32'(m_busy));
        chk("model_err",      32'(err),      32'(e_err));
    endtask

    typedef struct {
        logic rst, cwe; logic [CW-1:0] cch; logic [AW-1:0] clo, chi;
        logic wrq; logic [CW-1:0] wch; logic rds; logic [CW-1:0] rch; logic rdy;
        logic ewv; logic [AW-1:0] ewa; logic erv; logic [AW-1:0] era; logic erl, eb, ee;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(int r, int cwe, int cch, int clo, int chi, int wrq, int wch,
                                int rds, int rch, int rdy, int ewv, int ewa, int erv, int era,
                                int erl, int eb, int ee);
        vec_t v;
        v.rst = r[0]; v.cwe = cwe[0]; v.cch = cch[CW-1:0]; v.clo = clo[AW-1:0]; v.chi = chi[AW-1:0];
        v.wrq = wrq[0]; v.wch = wch[CW-1:0]; v.rds = rds[0]; v.rch = rch[CW-1:0]; v.rdy = rdy[0];
        v.ewv = ewv[0]; v.ewa = ewa[AW-1:0]; v.erv = erv[0]; v.era = era[AW-1:0];
        v.erl = erl[0]; v.eb = eb[0]; v.ee = ee[0];
        return v;
    endfunction

    initial begin
        model_reset();
        //            rst cwe ch  lo     hi     wrq wch rds rch rdy | wv wa     rv ra     rl b  e
        vecs.push_back(mk(1, 0, 0, 0,     0,     0, 0, 0, 0, 0,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 'h100, 'h103, 0, 0, 0, 0, 0,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 'h200, 'h20F, 0, 0, 0, 0, 0,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 'h050, 'h050, 0, 0, 0, 0, 0,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   1, 'h101, 0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   1, 'h102, 0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 1, 1,   0, 'h102, 1, 'h102, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 'h102, 1, 'h101, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   0, 'h102, 1, 'h101, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 2, 0, 0, 0,   1, 'h201, 1, 'h101, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 0,   0, 'h201, 1, 'h101, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 2, 1,   0, 'h201, 1, 'h100, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 'h100, 'h103, 0, 0, 0, 0, 1,   0, 'h201, 1, 'h103, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 3, 1,   0, 'h201, 0, 'h103, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   1, 'h103, 0, 'h103, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   1, 'h100, 0, 'h103, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 3, 1,   0, 'h100, 1, 'h050, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 'h100, 0, 'h050, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 'h010, 'h00F, 0, 0, 0, 0, 0,   0, 'h100, 0, 'h050, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 3, 0,   0, 'h100, 1, 'h050, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 'h100, 0, 'h050, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 2, 1,   0, 'h100, 1, 'h201, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 'h100, 1, 'h200, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 'h100, 1, 'h20F, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,     0,     1, 2, 1, 1, 1,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 1, 1, 1,   0, 0,     1, 0,     1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     0, 0, 0, 0, 1,   0, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 0, 0, 0,   1, 0,     0, 0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 'h300, 'h302, 1, 2, 0, 0, 0,   0, 0,     0, 0,     0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 2, 0, 0, 0,   1, 'h301, 0, 0,     0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; cfg_we = vecs[i].cwe; cfg_ch = vecs[i].cch;
            cfg_lo = vecs[i].clo; cfg_hi = vecs[i].chi;
            wr_req = vecs[i].wrq; wr_ch = vecs[i].wch;
            rd_start = vecs[i].rds; rd_ch = vecs[i].rch; rd_ready = vecs[i].rdy;
            cycle();
            chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'(vecs[i].ewv));
            chk($sformatf("v%0d_wr_addr", i),  32'(wr_addr),  32'(vecs[i].ewa));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].erv));
            chk($sformatf("v%0d_rd_addr", i),  32'(rd_addr),  32'(vecs[i].era));
            chk($sformatf("v%0d_rd_last", i),  32'(rd_last),  32'(vecs[i].erl));
            chk($sformatf("v%0d_busy", i),     32'(busy),     32'(vecs[i].eb));
            chk($sformatf("v%0d_err", i),      32'(err),      32'(vecs[i].ee));
        end

        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] lo_r;
            lo_r     = AW'($urandom_range(0, (1 << AW) - 1));
            rst      = ($urandom_range(0, 399) == 0);
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_ch   = CW'($urandom_range(0, CHN - 1));
            cfg_lo   = lo_r;
            cfg_hi   = ($urandom_range(0, 7) == 0) ? lo_r - AW'(1) : lo_r + AW'($urandom_range(0, 6));
            wr_req   = ($urandom_range(0, 9) < 3);
            wr_ch    = CW'($urandom_range(0, CHN - 1));
            rd_start = ($urandom_range(0, 9) == 0);
            rd_ch    = CW'($urandom_range(0, CHN - 1));
            rd_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_ramdrv_ringbuf_mc.md
CTRL_RAMDRV_RINGBUF_MC -- requirements
Module: ctrl_ramdrv_ringbuf_mc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, RAM sample address width.
REQ-002 SHALL have parameter CH_NUM, default 4, number of independent ring-buffer channels (2..16).
REQ-003 SHALL have parameter CH_WIDTH, default 2, channel index width; CH_WIDTH >= clog2(CH_NUM).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cfg_we / cfg_ch / cfg_lo / cfg_hi  input  1 / CH_WIDTH / ADDR_WIDTH / ADDR_WIDTH  segment configuration strobe, channel, lowest address, highest address.
REQ-007 SHALL have ports wr_req / wr_ch  input  1 / CH_WIDTH  new-sample push request and channel.
REQ-008 SHALL have ports wr_valid / wr_addr  output  1 / ADDR_WIDTH  write-address strobe and address for the pushed sample.
REQ-009 SHALL have ports rd_start / rd_ch / rd_ready  input  1 / CH_WIDTH / 1  scan start, scan channel, consumer ready.
REQ-010 SHALL have ports rd_valid / rd_addr / rd_last  output  1 / ADDR_WIDTH / 1  scan address valid, address, final address flag.
REQ-011 SHALL have ports busy / err  output  1 / 1  scan in progress; one-cycle rejected-command pulse.

Function
REQ-012 SHALL store per channel lo, hi, head (newest sample address) registers.
REQ-013 cfg_we with cfg_lo <= cfg_hi SHALL load lo=cfg_lo, hi=cfg_hi, head=cfg_lo for cfg_ch on the next edge.
REQ-014 cfg_we with cfg_lo > cfg_hi, cfg_ch >= CH_NUM, or cfg_ch equal to the channel being scanned SHALL be ignored and pulse err.
REQ-015 Accepted wr_req SHALL update head <= (head==hi) ? lo : head+1 and assert wr_valid with wr_addr = new head one cycle after wr_req.
REQ-016 wr_req on the channel currently scanned, or with wr_ch >= CH_NUM, SHALL be dropped, head unchanged, err pulsed, wr_valid low.
REQ-017 cfg_we and wr_req on the same channel in the same cycle: configuration SHALL win, push dropped, err pulsed.
REQ-018 FSM states SHALL be IDLE and SCAN; rst forces IDLE.
REQ-019 IDLE: rd_start with valid rd_ch SHALL latch channel and its lo/hi/head, go to SCAN; rd_valid=1, rd_addr=head on the next cycle (latency 1).
REQ-020 SCAN: on rd_valid & rd_ready, rd_addr SHALL step (rd_addr==lo) ? hi : rd_addr-1; rd_valid & !rd_ready SHALL hold rd_addr, rd_last.
REQ-021 A scan SHALL emit exactly hi-lo+1 addresses, newest to oldest; rd_last SHALL be high with the final address (tail = head+1 with wrap, or head when lo==hi).
REQ-022 Handshake of final address (rd_valid & rd_ready & rd_last) SHALL return to IDLE; rd_valid, busy low the following cycle.
REQ-023 busy SHALL equal (state==SCAN).
REQ-024 rd_start while busy, or with rd_ch >= CH_NUM, SHALL be ignored and pulse err.
REQ-025 rd_start in the cycle the final address completes SHALL be rejected (err); a new scan needs one IDLE cycle.
REQ-026 Pushes and configs on non-scanned channels SHALL proceed concurrently with a scan.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; no address outside [lo,hi] SHALL be emitted.

Reset
REQ-028 rst high at an edge SHALL clear all lo/hi/head to 0, state IDLE, wr_valid, rd_valid, rd_last, busy, err to 0, wr_addr and rd_addr to 0.
REQ-029 rst mid-scan SHALL abort the scan without emitting further addresses; rst dominates all other inputs.

Verification
REQ-030 cfg ch1 lo=0x100 hi=0x103; two pushes ch1 -> wr_addr 0x101, 0x102; scan ch1, rd_ready=1 -> 0x102, 0x101, 0x100, 0x103, rd_last with 0x103.
REQ-031 Push ch1 with head=0x103 -> wr_addr 0x100 (wrap).
REQ-032 rd_ready low 3 cycles at second address -> rd_addr holds 0x101, rd_valid stays 1, scan resumes with 0x100.
REQ-033 Push ch1 during scan ch1 -> err pulse, head unchanged; same-cycle push ch2 (lo=0x200, hi=0x20F) -> wr_addr 0x201.
REQ-034 cfg ch3 lo=hi=0x050; scan ch3 -> single address 0x050 with rd_last=1; cfg lo=0x10 hi=0x0F -> err, registers unchanged.
REQ-035 rst asserted at third scan address -> next cycle rd_valid=0, busy=0, all heads 0.
